// File: rtl/prbs7_checker.sv
// prbs7_checker
//   Self-synchronising PRBS7 (x^7 + x^6 + 1) checker for an aligned receive
//   word stream. Each received bit is predicted from the received bits 7 and 6
//   positions earlier. Locks after LOCK_CNT clean words in a row. Loses lock
//   after UNLOCK_CNT errored words in a row. Error and word counters advance
//   only while locked.
//
// Ports
//   clk          receive word clock (single clock domain)
//   reset        synchronous, active-low
//   din_valid    din carries a word this cycle
//   din          aligned word, bit 0 = earliest serial bit
//   clear_cnt    synchronous clear of error_count / word_count (wins over update)
//   locked       stream locked
//   word_err     one-cycle pulse for an errored word checked while locked
//   bit_errs     mismatch count of the last checked word
//   error_count  saturating count of errored bits while locked
//   word_count   saturating count of words checked while locked
module prbs7_checker #(
  parameter int WORDWIDTH  = 32,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_CNT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din_valid,
  input  logic [WORDWIDTH-1:0] din,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 word_err,
  output logic [5:0]           bit_errs,
  output logic [31:0]          error_count,
  output logic [31:0]          word_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  typedef enum logic [1:0] {S_INIT, S_HUNT, S_LOCK} state_t;

  state_t          r_state, w_state_nxt;
  logic [GW-1:0]   r_good, w_good_nxt;
  logic [BW-1:0]   r_bad, w_bad_nxt;
  logic [6:0]      r_hist;
  logic            r_word_err;
  logic [5:0]      r_bit_errs;
  logic [31:0]     r_error_count;
  logic [31:0]     r_word_count;

  // Serial stream for this word: previous word's last 7 bits, then din.
  // Bit i of din sits at w_ext[i+7]; its predictors are w_ext[i] and w_ext[i+1].
  logic [WORDWIDTH+6:0] w_ext;
  logic [WORDWIDTH-1:0] w_expect;
  logic [WORDWIDTH-1:0] w_diff;
  logic [5:0]           w_pop;
  logic [5:0]           w_mis;
  logic                 w_stuck;
  logic                 w_err;
  logic [32:0]          w_ec_sum;
  logic [31:0]          w_ec_nxt;
  logic [31:0]          w_wc_nxt;

  assign w_ext = {din, r_hist};

  for (genvar gi = 0; gi < WORDWIDTH; gi++) begin : g_exp
    assign w_expect[gi] = w_ext[gi] ^ w_ext[gi+1];
  end

  assign w_diff = din ^ w_expect;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WORDWIDTH; i++) w_pop = w_pop + 6'(w_diff[i]);
  end

  // An all-zero stream predicts itself perfectly, so flag it explicitly and
  // charge every bit of the word as wrong.
  assign w_stuck = (din == '0) && (r_hist == '0);
  assign w_mis   = w_stuck ? 6'(WORDWIDTH) : w_pop;
  assign w_err   = w_stuck || (w_pop != '0);

  assign w_ec_sum = {1'b0, r_error_count} + 33'(w_mis);
  assign w_ec_nxt = w_ec_sum[32] ? 32'hFFFF_FFFF : w_ec_sum[31:0];
  assign w_wc_nxt = (r_word_count == 32'hFFFF_FFFF) ? r_word_count : r_word_count + 32'd1;

  // Next state and run counters; counters are cleared on every transition.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    if (din_valid) begin
      case (r_state)
        S_INIT: begin
          w_state_nxt = S_HUNT;
          w_good_nxt  = '0;
          w_bad_nxt   = '0;
        end
        S_HUNT: begin
          if (w_err) begin
            w_good_nxt = '0;
          end else if (r_good == GW'(LOCK_CNT - 1)) begin
            w_state_nxt = S_LOCK;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
          end else begin
            w_good_nxt = r_good + GW'(1);
          end
        end
        S_LOCK: begin
          if (!w_err) begin
            w_bad_nxt = '0;
          end else if (r_bad == BW'(UNLOCK_CNT - 1)) begin
            w_state_nxt = S_HUNT;
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
          end else begin
            w_bad_nxt = r_bad + BW'(1);
          end
        end
        default: begin
          w_state_nxt = S_INIT;
          w_good_nxt  = '0;
          w_bad_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_INIT;
      r_good        <= '0;
      r_bad         <= '0;
      r_hist        <= '0;
      r_word_err    <= 1'b0;
      r_bit_errs    <= '0;
      r_error_count <= '0;
      r_word_count  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good     <= w_good_nxt;
      r_bad      <= w_bad_nxt;
      r_word_err <= din_valid && (r_state == S_LOCK) && w_err;
      if (din_valid) r_hist <= din[WORDWIDTH-1 -: 7];
      if (din_valid && (r_state != S_INIT)) r_bit_errs <= w_mis;
      if (clear_cnt) begin
        r_error_count <= '0;
        r_word_count  <= '0;
      end else if (din_valid && (r_state == S_LOCK)) begin
        r_error_count <= w_ec_nxt;
        r_word_count  <= w_wc_nxt;
      end
    end
  end

  assign locked      = (r_state == S_LOCK);
  assign word_err    = r_word_err;
  assign bit_errs    = r_bit_errs;
  assign error_count = r_error_count;
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: lock-up, single-bit flip, stuck-zero
// unlock, relock, counter saturation and clear, mid-lock reset and gapped
// din_valid.
module tb_prbs7_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        din_valid;
  logic [31:0] din;
  logic        clear_cnt;
  logic        locked;
  logic        word_err;
  logic [5:0]  bit_errs;
  logic [31:0] error_count;
  logic [31:0] word_count;

  prbs7_checker #(.WORDWIDTH(32), .LOCK_CNT(8), .UNLOCK_CNT(4)) dut (
    .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
    .clear_cnt(clear_cnt), .locked(locked), .word_err(word_err),
    .bit_errs(bit_errs), .error_count(error_count), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [6:0]  h;          // generator history, h[0] oldest bit
  logic [31:0] w;
  logic [31:0] exp_ec;
  int          k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next 32 PRBS7 bits, s[n] = s[n-7] ^ s[n-6].
  task automatic next_word(output logic [31:0] o);
    logic b;
    for (int i = 0; i < 32; i++) begin
      b    = h[0] ^ h[1];
      o[i] = b;
      h    = {b, h[6:1]};
    end
  endtask

  // Mismatches of an all-zero word following the current history: only
  // bits 0..6 have nonzero predictions.
  function automatic int zero_word_errs(input logic [6:0] hh);
    int s;
    s = 0;
    for (int i = 0; i < 6; i++) s += int'(hh[i] ^ hh[i+1]);
    s += int'(hh[6]);
    return s;
  endfunction

  task automatic send(input logic [31:0] d, input logic v, input logic clr);
    din       = d;
    din_valid = v;
    clear_cnt = clr;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clear_cnt = 1'b0;
  endtask

  initial begin
    reset = 1'b0; din_valid = 1'b0; din = '0; clear_cnt = 1'b0; h = 7'h7F;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked",   32'(locked),   32'd0);
    chk("rst_word_err", 32'(word_err), 32'd0);
    chk("rst_bit_errs", 32'(bit_errs), 32'd0);
    chk("rst_err_cnt",  error_count,   32'd0);
    chk("rst_word_cnt", word_count,    32'd0);
    reset = 1'b1;

    // Load word + 7 clean words: still hunting.
    for (int i = 1; i <= 8; i++) begin
      next_word(w); send(w, 1'b1, 1'b0);
      chk("hunt_locked", 32'(locked), 32'd0);
      chk("hunt_werr",   32'(word_err), 32'd0);
    end
    next_word(w); send(w, 1'b1, 1'b0);
    chk("lock_9th",      32'(locked), 32'd1);
    chk("lock_wc_zero",  word_count,  32'd0);

    for (int i = 0; i < 100; i++) begin
      next_word(w); send(w, 1'b1, 1'b0);
      chk("clean_werr", 32'(word_err), 32'd0);
    end
    chk("clean_wc",     word_count,  32'd100);
    chk("clean_ec",     error_count, 32'd0);
    chk("clean_locked", 32'(locked), 32'd1);

    // Single flip at bit 10: bits 10, 16, 17 mismatch.
    next_word(w); send(w ^ 32'h0000_0400, 1'b1, 1'b0);
    chk("flip_werr",   32'(word_err), 32'd1);
    chk("flip_biterr", 32'(bit_errs), 32'd3);
    chk("flip_ec",     error_count,   32'd3);
    chk("flip_locked", 32'(locked),   32'd1);
    send('0, 1'b0, 1'b0);
    chk("idle_werr",   32'(word_err), 32'd0);
    chk("idle_biterr", 32'(bit_errs), 32'd3);
    next_word(w); send(w, 1'b1, 1'b0);
    chk("after_biterr", 32'(bit_errs), 32'd0);
    chk("after_wc",     word_count,    32'd102);

    // Four zero words: first one is charged its predicted ones, the rest
    // are stuck-zero (32 each); lock drops on the fourth.
    k      = zero_word_errs(h);
    exp_ec = 32'(3 + k + 96);
    for (int z = 1; z <= 4; z++) begin
      send('0, 1'b1, 1'b0);
      chk("zero_werr",   32'(word_err), 32'd1);
      chk("zero_locked", 32'(locked),   (z < 4) ? 32'd1 : 32'd0);
    end
    chk("zero_ec",     error_count,   exp_ec);
    chk("zero_wc",     word_count,    32'd106);
    chk("zero_biterr", 32'(bit_errs), 32'd32);

    // Relock: first word after zeros is errored, then 8 clean words.
    next_word(w); send(w, 1'b1, 1'b0);
    chk("relock_werr", 32'(word_err), 32'd0);
    chk("relock_ec",   error_count,   exp_ec);
    for (int i = 0; i < 7; i++) begin
      next_word(w); send(w, 1'b1, 1'b0);
      chk("relock_hunt", 32'(locked), 32'd0);
    end
    next_word(w); send(w, 1'b1, 1'b0);
    chk("relock_lock", 32'(locked), 32'd1);

    // Saturation then clear.
    k      = zero_word_errs(h);
    exp_ec = exp_ec + 32'(k);
    send('0, 1'b1, 1'b0);
    chk("sat_pre_ec", error_count, exp_ec);
    chk("sat_pre_wc", word_count,  32'd107);
    force dut.r_error_count = 32'hFFFF_FFF0;
    @(posedge clk);
    #1;
    release dut.r_error_count;
    send('0, 1'b1, 1'b0);
    chk("sat_ec",     error_count,   32'hFFFF_FFFF);
    chk("sat_biterr", 32'(bit_errs), 32'd32);
    chk("sat_locked", 32'(locked),   32'd1);
    chk("sat_wc",     word_count,    32'd108);
    send('0, 1'b1, 1'b1);
    chk("clr_ec",     error_count,   32'd0);
    chk("clr_wc",     word_count,    32'd0);
    chk("clr_werr",   32'(word_err), 32'd1);
    chk("clr_locked", 32'(locked),   32'd1);

    // One-cycle reset while locked.
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("mid_rst_locked", 32'(locked),   32'd0);
    chk("mid_rst_biterr", 32'(bit_errs), 32'd0);
    chk("mid_rst_werr",   32'(word_err), 32'd0);

    // Relock with din_valid toggling: same count in valid words.
    for (int i = 1; i <= 9; i++) begin
      next_word(w); send(w, 1'b1, 1'b0);
      chk("gap_locked", 32'(locked), (i < 9) ? 32'd1 * 0 : 32'd1);
      send('0, 1'b0, 1'b0);
      chk("gap_idle_werr", 32'(word_err), 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      next_word(w); send(w, 1'b1, 1'b0);
      chk("gap_werr", 32'(word_err), 32'd0);
      send('0, 1'b0, 1'b0);
    end
    chk("gap_wc",     word_count,  32'd10);
    chk("gap_ec",     error_count, 32'd0);
    chk("gap_locked", 32'(locked), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
